// File: rtl/cic_pdm_decim_mc_pkg.sv
// Shared constants and sizing helpers for the multi-channel PDM CIC decimator.
// The internal width leaves headroom for the largest ratio plus a sign bit.
package cic_pdm_pkg;

    localparam int PDM_ONE  = 1;
    localparam int PDM_ZERO = -1;

    function automatic int cic_bw(input int order, input int dec_log2_max);
        return order * dec_log2_max + 2;
    endfunction

    // Positive result: arithmetic right shift; negative: left shift by its magnitude.
    function automatic int scale_shift(input int order, input int dec_log2, input int out_w);
        return order * dec_log2 + 1 - out_w;
    endfunction

endpackage

// File: rtl/cic_pdm_decim_mc_if.sv
// PDM sample input and PCM valid/ready output bundle of the CIC decimator.
// slave is the decimator side, master is the producer/consumer side.
interface cic_pdm_decim_mc_if #(
    parameter int CHANNELS = 2,
    parameter int OUT_W    = 16
);
    logic                      in_valid;
    logic [CHANNELS-1:0]       pdm_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [CHANNELS*OUT_W-1:0] out_data;

    modport master (output in_valid, pdm_in, out_ready, input out_valid, out_data);
    modport slave  (input in_valid, pdm_in, out_ready, output out_valid, out_data);
endinterface

// File: rtl/cic_pdm_decim_mc_chan.sv
// One channel of the CIC: integrators, comb chain, output scaling and saturation.
// Sequencing (accept, capture, load) is driven by the shared control in the top.
module cic_chan
    import cic_pdm_pkg::*;
#(
    parameter int ORDER        = 3,
    parameter int DEC_LOG2_MAX = 6,
    parameter int OUT_W        = 16
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_acc,
    input  logic             i_pdm,
    input  logic             i_cap,
    input  logic             i_load,
    input  logic [2:0]       i_dec_log2,
    output logic [OUT_W-1:0] o_data,
    output logic             o_clip
);
    localparam int B  = cic_bw(ORDER, DEC_LOG2_MAX);
    localparam int WW = B + OUT_W;
    localparam longint SAT_MAX_L = (longint'(1) <<< (OUT_W - 1)) - 1;
    localparam logic signed [WW-1:0] SAT_MAX = WW'(SAT_MAX_L);
    localparam logic signed [WW-1:0] SAT_MIN = WW'(-SAT_MAX_L - 1);

    logic signed [B-1:0]  w_x;
    logic signed [B-1:0]  r_int      [ORDER];
    logic signed [B-1:0]  w_int_next [ORDER];
    logic signed [B-1:0]  r_dly      [ORDER];
    logic signed [B-1:0]  w_c        [ORDER+1];
    logic signed [B-1:0]  r_comb_in;
    logic signed [WW-1:0] w_wide;
    logic signed [WW-1:0] w_scaled;
    logic [OUT_W-1:0]     w_sat;
    logic [OUT_W-1:0]     r_data;
    logic                 w_clip;
    int                   w_shift;

    assign w_x = i_pdm ? B'(PDM_ONE) : B'(PDM_ZERO);

    // Cascade sees the freshly updated previous stage, so all stages advance per sample.
    always_comb begin
        w_int_next[0] = r_int[0] + w_x;
        for (int k = 1; k < ORDER; k++) begin
            w_int_next[k] = r_int[k] + w_int_next[k-1];
        end
    end

    always_comb begin
        w_c[0] = r_comb_in;
        for (int k = 0; k < ORDER; k++) begin
            w_c[k+1] = w_c[k] - r_dly[k];
        end
    end

    always_comb begin
        w_shift  = scale_shift(ORDER, int'(i_dec_log2), OUT_W);
        w_wide   = {{OUT_W{w_c[ORDER][B-1]}}, w_c[ORDER]};
        w_scaled = w_wide;
        if (w_shift >= 0) begin
            w_scaled = w_wide >>> w_shift;
        end else begin
            w_scaled = w_wide <<< (-w_shift);
        end
        w_clip = 1'b0;
        w_sat  = w_scaled[OUT_W-1:0];
        if (w_scaled > SAT_MAX) begin
            w_sat  = SAT_MAX[OUT_W-1:0];
            w_clip = 1'b1;
        end else if (w_scaled < SAT_MIN) begin
            w_sat  = SAT_MIN[OUT_W-1:0];
            w_clip = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_clr) begin
            for (int k = 0; k < ORDER; k++) begin
                r_int[k] <= '0;
                r_dly[k] <= '0;
            end
            r_comb_in <= '0;
            r_data    <= '0;
        end else begin
            if (i_acc) begin
                for (int k = 0; k < ORDER; k++) begin
                    r_int[k] <= w_int_next[k];
                end
            end
            if (i_cap) begin
                r_comb_in <= r_int[ORDER-1];
            end
            if (i_load) begin
                for (int k = 0; k < ORDER; k++) begin
                    r_dly[k] <= w_c[k];
                end
                r_data <= w_sat;
            end
        end
    end

    assign o_data = r_data;
    assign o_clip = w_clip;

endmodule

// File: rtl/cic_pdm_decim_mc.sv
// Multi-channel PDM-to-PCM CIC decimator with runtime power-of-two ratio.
// Holds the shared counter, ratio latch, output handshake and sticky flags.
module cic_pdm_decim_mc
    import cic_pdm_pkg::*;
#(
    parameter int CHANNELS     = 2,
    parameter int ORDER        = 3,
    parameter int DEC_LOG2_MAX = 6,
    parameter int OUT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [2:0]           dec_log2,
    cic_pdm_decim_mc_if.slave    bus,
    output logic                 overrun,
    output logic                 sat
);
    localparam int CW = DEC_LOG2_MAX;

    logic                      r_en_d;
    logic [2:0]                r_ratio;
    logic [2:0]                w_clamped;
    logic [2:0]                w_ratio;
    logic [CW:0]               w_pow;
    logic [CW-1:0]             w_last;
    logic [CW-1:0]             r_cnt;
    logic                      w_rise;
    logic                      w_clr;
    logic                      w_acc;
    logic                      w_strobe;
    logic                      r_cap;
    logic                      r_load;
    logic                      r_out_valid;
    logic                      r_overrun;
    logic                      r_sat;
    logic [CHANNELS-1:0]       w_clip;
    logic [CHANNELS*OUT_W-1:0] w_data;

    always_comb begin
        w_clamped = dec_log2;
        if (dec_log2 == 3'd0) begin
            w_clamped = 3'd1;
        end else if (int'(dec_log2) > DEC_LOG2_MAX) begin
            w_clamped = 3'(DEC_LOG2_MAX);
        end
    end

    // The ratio applies to a sample accepted on the very edge en rises.
    assign w_rise   = en & ~r_en_d;
    assign w_ratio  = w_rise ? w_clamped : r_ratio;
    assign w_pow    = (CW+1)'(1) << w_ratio;
    assign w_last   = CW'(w_pow - (CW+1)'(1));
    assign w_clr    = rst | ~en;
    assign w_acc    = en & bus.in_valid;
    assign w_strobe = w_acc & (r_cnt == w_last);

    // The ratio survives rst: only a 0->1 transition of en reloads it, and an
    // en held high through rst is not treated as a new transition.
    always_ff @(posedge clk) begin
        r_en_d <= en;
        if (w_rise) begin
            r_ratio <= w_clamped;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_cnt       <= '0;
            r_cap       <= 1'b0;
            r_load      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_acc) begin
                r_cnt <= w_strobe ? '0 : r_cnt + CW'(1);
            end
            r_cap  <= w_strobe;
            r_load <= r_cap;
            if (r_load) begin
                r_out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
            r_sat     <= 1'b0;
        end else if (en && r_load) begin
            if (r_out_valid && !bus.out_ready) begin
                r_overrun <= 1'b1;
            end
            if (|w_clip) begin
                r_sat <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            cic_chan #(
                .ORDER       (ORDER),
                .DEC_LOG2_MAX(DEC_LOG2_MAX),
                .OUT_W       (OUT_W)
            ) u_chan (
                .clk       (clk),
                .i_clr     (w_clr),
                .i_acc     (w_acc),
                .i_pdm     (bus.pdm_in[gi]),
                .i_cap     (r_cap),
                .i_load    (r_load),
                .i_dec_log2(r_ratio),
                .o_data    (w_data[gi*OUT_W +: OUT_W]),
                .o_clip    (w_clip[gi])
            );
        end
    endgenerate

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = w_data;
    assign overrun       = r_overrun;
    assign sat           = r_sat;

endmodule

// File: tb/tb_cic_pdm_decim_mc.sv
// Scoreboard bench for cic_pdm_decim_mc: a sum/difference reference model queues
// expected samples with their due edge; a negedge monitor tracks the handshake.
module tb_cic_pdm_decim_mc;
    localparam int CH  = 2;
    localparam int ORD = 3;
    localparam int DLM = 6;
    localparam int OW  = 16;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       en       = 1'b0;
    logic [2:0] dec_log2 = 3'd6;
    logic       overrun;
    logic       sat;

    cic_pdm_decim_mc_if #(.CHANNELS(CH), .OUT_W(OW)) bus ();

    cic_pdm_decim_mc #(
        .CHANNELS(CH), .ORDER(ORD), .DEC_LOG2_MAX(DLM), .OUT_W(OW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .dec_log2(dec_log2),
        .bus(bus), .overrun(overrun), .sat(sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [CH*OW-1:0] data;
        bit               clip;
        int               due;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    longint m_acc  [CH][ORD];
    longint m_hist [CH][ORD+1];
    int     m_n;
    int     m_ratio = DLM;
    bit     m_prev_en = 1'b0;

    function automatic void chk(input string name, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d cycle=%0d", name, act, want, cyc);
        end
    endfunction

    function automatic longint binom(input int n, input int k);
        longint r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    function automatic int clamp_ratio(input logic [2:0] d);
        if (d == 3'd0) return 1;
        if (int'(d) > DLM) return DLM;
        return int'(d);
    endfunction

    task automatic model_clear();
        m_n = 0;
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < ORD; k++) m_acc[c][k] = 0;
            for (int k = 0; k <= ORD; k++) m_hist[c][k] = 0;
        end
    endtask

    // Output = ORDER-th backward difference of the ORDER-fold running sum,
    // taken every R accepted samples, then scaled and clipped.
    task automatic model_accept(input logic [CH-1:0] p);
        exp_t   e;
        longint y, v, maxv, minv;
        int     sh;
        m_n++;
        for (int c = 0; c < CH; c++) begin
            m_acc[c][0] += p[c] ? 1 : -1;
            for (int k = 1; k < ORD; k++) m_acc[c][k] += m_acc[c][k-1];
        end
        if (m_n == (1 << m_ratio)) begin
            m_n    = 0;
            e.data = '0;
            e.clip = 1'b0;
            maxv   = (longint'(1) <<< (OW - 1)) - 1;
            minv   = -maxv - 1;
            sh     = ORD * m_ratio + 1 - OW;
            for (int c = 0; c < CH; c++) begin
                for (int j = ORD; j > 0; j--) m_hist[c][j] = m_hist[c][j-1];
                m_hist[c][0] = m_acc[c][ORD-1];
                y = 0;
                for (int j = 0; j <= ORD; j++)
                    y += ((j % 2) ? -1 : 1) * binom(ORD, j) * m_hist[c][j];
                v = (sh >= 0) ? (y >>> sh) : (y <<< (-sh));
                if (v > maxv) begin v = maxv; e.clip = 1'b1; end
                if (v < minv) begin v = minv; e.clip = 1'b1; end
                e.data[c*OW +: OW] = OW'(v);
            end
            e.due = cyc + 3;
            q.push_back(e);
        end
    endtask

    task automatic step(input bit t_rst, input bit t_en, input bit t_iv,
                        input logic [CH-1:0] t_pdm, input bit t_rdy);
        @(posedge clk);
        #1;
        rst           = t_rst;
        en            = t_en;
        bus.in_valid  = t_iv;
        bus.pdm_in    = t_pdm;
        bus.out_ready = t_rdy;
        if (t_en && !m_prev_en) m_ratio = clamp_ratio(dec_log2);
        m_prev_en = t_en;
        if (t_rst || !t_en) model_clear();
        else if (t_iv) model_accept(t_pdm);
    endtask

    task automatic drain(input bit t_en);
        int n = 0;
        while (q.size() > 0 && n < 40) begin
            step(1'b0, t_en, 1'b0, '0, 1'b1);
            n++;
        end
        step(1'b0, t_en, 1'b0, '0, 1'b1);
        step(1'b0, t_en, 1'b0, '0, 1'b1);
        chk("drain_queue_empty", q.size(), 0);
    endtask

    bit               mp_rst = 1'b1, mp_en = 1'b0, mp_rdy = 1'b1;
    bit               me_valid = 1'b0, me_ovr = 1'b0, me_sat = 1'b0;
    bit               mload, mxfer;
    logic [CH*OW-1:0] me_data = '0;
    exp_t             ment;

    // Monitor: replays the edge that just happened on the expected handshake state.
    initial begin
        forever begin
            @(negedge clk);
            if (mp_rst) begin
                q.delete();
                me_valid = 1'b0; me_ovr = 1'b0; me_sat = 1'b0;
            end else if (!mp_en) begin
                q.delete();
                me_valid = 1'b0;
            end else begin
                mxfer = me_valid & mp_rdy;
                mload = 1'b0;
                while (q.size() > 0 && q[0].due <= cyc) begin
                    ment  = q.pop_front();
                    mload = 1'b1;
                end
                if (mload) begin
                    if (me_valid && !mxfer) me_ovr = 1'b1;
                    me_valid = 1'b1;
                    me_data  = ment.data;
                    me_sat   = me_sat | ment.clip;
                end else if (mxfer) begin
                    me_valid = 1'b0;
                end
            end
            chk("out_valid", longint'(bus.out_valid), longint'(me_valid));
            if (me_valid) begin
                for (int c = 0; c < CH; c++)
                    chk($sformatf("out_data_ch%0d", c),
                        longint'($signed(bus.out_data[c*OW +: OW])),
                        longint'($signed(me_data[c*OW +: OW])));
            end
            chk("overrun", longint'(overrun), longint'(me_ovr));
            chk("sat", longint'(sat), longint'(me_sat));
            mp_rst = rst;
            mp_en  = en;
            mp_rdy = bus.out_ready;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish cycle=%0d", cyc);
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.pdm_in    = '0;
        bus.out_ready = 1'b1;
        model_clear();
        repeat (3) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_sat", sat, 0);

        // R=64, ch0 constant +1, ch1 constant -1
        dec_log2 = 3'd6;
        repeat (64 * 6) step(1'b0, 1'b1, 1'b1, 2'b01, 1'b1);
        drain(1'b1);
        chk("dc_ch0_full_pos", $signed(bus.out_data[0 +: OW]), 32767);
        chk("dc_ch1_full_neg", $signed(bus.out_data[OW +: OW]), -32768);
        chk("dc_sat_set", sat, 1);

        // Alternating input settles to zero without clipping
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 64 * 5; i++)
            step(1'b0, 1'b1, 1'b1, (i % 2) ? 2'b00 : 2'b11, 1'b1);
        drain(1'b1);
        chk("alt_settled_zero", bus.out_data, 0);
        chk("alt_sat_clear", sat, 0);

        // R=4: left shift path, full scale clips
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        dec_log2 = 3'd2;
        repeat (4 * 8) step(1'b0, 1'b1, 1'b1, 2'b11, 1'b1);
        drain(1'b1);
        chk("r4_sat_set", sat, 1);

        // R=64 random data with in_valid gaps
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        dec_log2 = 3'd6;
        repeat (64 * 8) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), CH'($urandom), 1'b1);
        drain(1'b1);

        // R=8 random data, random gaps and random back-pressure
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        dec_log2 = 3'd3;
        repeat (400) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), CH'($urandom),
                          1'($urandom_range(0, 1)));
        drain(1'b1);

        // Back-pressure across three R=8 periods
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        repeat (8 * 3 + 4) step(1'b0, 1'b1, 1'b1, CH'($urandom), 1'b0);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("bp_valid_held", bus.out_valid, 1);
        chk("bp_overrun_set", overrun, 1);
        step(1'b0, 1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 1'b0, '0, 1'b1);
        chk("bp_valid_dropped", bus.out_valid, 0);
        drain(1'b1);

        // rst mid-frame; dec_log2 change while enabled is ignored until en re-rises
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        dec_log2 = 3'd6;
        repeat (30) step(1'b0, 1'b1, 1'b1, 2'b10, 1'b1);
        dec_log2 = 3'd2;
        step(1'b1, 1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 1'b0, '0, 1'b1);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_out_data", bus.out_data, 0);
        repeat (64 * 2) step(1'b0, 1'b1, 1'b1, CH'($urandom), 1'b1);
        drain(1'b1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        repeat (4 * 6) step(1'b0, 1'b1, 1'b1, CH'($urandom), 1'b1);
        drain(1'b1);

        // Out-of-range ratios clamp to 1 and DEC_LOG2_MAX
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        dec_log2 = 3'd0;
        repeat (2 * 10) step(1'b0, 1'b1, 1'b1, CH'($urandom), 1'b1);
        drain(1'b1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        dec_log2 = 3'd7;
        repeat (64 * 2) step(1'b0, 1'b1, 1'b1, CH'($urandom), 1'b1);
        drain(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cic_pdm_decim_mc.md
Name: cic_pdm_decim_mc

Overview:
Multi-channel, parametrised CIC decimator for the sonar PDM front end. It is the successor to the single-channel fixed-rate CIC. It converts CHANNELS 1-bit PDM streams into signed OUT_W-bit PCM samples. Order and maximum rate are set at build time; the decimation rate is selected at runtime as a power of two. Output uses a valid/ready handshake, with saturation and overrun reporting. It sits between the PDM microphone/capture interface and the downstream FIR/beamforming stages.

Parameters:
CHANNELS, 2, number of independent PDM channels
ORDER, 3, number of integrator stages and number of comb stages (1..5)
DEC_LOG2_MAX, 6, maximum log2 of the decimation ratio R
OUT_W, 16, output sample width (signed)

Ports:
clk  in  1  single system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  block enable; low = flush and hold idle
dec_log2  in  3  log2(R); valid range 1..DEC_LOG2_MAX; sampled on the en 0->1 edge only
in_valid  in  1  pdm_in holds a new PDM sample this cycle
pdm_in  in  CHANNELS  one PDM bit per channel; 1 -> +1, 0 -> -1
out_valid  out  1  out_data holds an untransferred sample
out_ready  in  1  consumer accepts out_data when out_valid is high
out_data  out  CHANNELS*OUT_W  channel c occupies bits [c*OUT_W +: OUT_W], signed
overrun  out  1  sticky; set when an untransferred sample is overwritten
sat  out  1  sticky; set when any channel output saturates

Behaviour:
- Reset (rst=1 at a clock edge): all integrator, comb and delay registers = 0; decimation counter = 0; out_valid=0; out_data=0; overrun=0; sat=0. Reset mid-decimation discards the partial frame.
- en=0: same clearing as reset, except overrun and sat hold their values. Sticky flags are cleared only by rst.
- en 0->1: latch dec_log2 into an internal ratio register. If the value is out of range, clamp it into 1..DEC_LOG2_MAX. Changes to dec_log2 while en=1 are ignored.
- Internal width B = ORDER*DEC_LOG2_MAX + 2. Integrators and combs use two's-complement modular wrap at B bits. Wrap is intentional; there is no overflow detection inside the chain.
- Sample acceptance: a sample is accepted when en & in_valid. Each integrator updates on accepted samples only. Counter cnt increments per accepted sample and wraps at R-1 -> 0.
- Decimation strobe: fires when the R-th sample (cnt==R-1) is accepted. On the next edge, the last-integrator value is registered into the comb input.
- Comb stages: each computes y = x - x_delayed(1 decimated sample). Delays update only on strobe.
- Output register: loads on the edge after the comb input register.
- Latency: out_valid rises on the 2nd rising edge after the edge that accepted the R-th sample.
- Scaling: K = ORDER*dec_log2. Full-scale comb output is ±2^K.
  - s = K+1-OUT_W. If s>=0, apply arithmetic right shift by s. If s<0, apply left shift by -s.
  - Saturate the result to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Any clip sets sat.
- Handshake:
  - Transfer occurs when out_valid & out_ready. out_valid drops after a transfer unless a new sample loads on the same edge.
  - If a new sample loads while out_valid=1 and out_ready=0: the new sample overwrites out_data, out_valid stays 1, and overrun is set.
  - If a transfer and a load happen on the same edge: this is not an overrun; the new sample is presented.
  - out_data is stable while out_valid=1 and out_ready=0, except on overwrite.
- All channels share the counter, strobe and handshake. Channels are arithmetically independent.

Decomposition:
- Package cic_pdm_pkg holds:
  - internal-width function cic_bw(ORDER, DEC_LOG2_MAX)
  - constants for the PDM mapping (+1/-1)
  - function for the scale shift
- Sub-module cic_chan: the per-channel integrator/comb/scale/saturate datapath, instantiated CHANNELS times via generate. The top level holds the counter, ratio latch, handshake and sticky flags.

Test Plan:
- Defaults, dec_log2=6 (R=64), ch0 all-ones, ch1 all-zeros, out_ready=1 -> from the 4th output onward ch0=32767 (sat set), ch1=-32768 (no clip from ch1 alone). out_valid pulses once per 64 accepted samples, 2 cycles after the 64th.
- dec_log2=6, both channels alternating 1,0 -> settled outputs = 0; sat stays 0.
- dec_log2=2 (K=6, left shift 9), all-ones -> 64<<9 = 32768 saturates to 32767; sat=1.
- out_ready=0 across 3 decimation periods -> out_valid held, out_data = latest sample, overrun=1. Then out_ready=1 -> a single transfer and out_valid drops.
- in_valid gated low 50% of cycles -> output values identical to the gapless run; outputs occur only per 64 accepted samples.
- rst asserted mid-frame (cnt=30) and dec_log2 changed while en=1 -> all outputs 0 after rst; the old ratio is kept until en toggles 0->1, then the new R applies.
